// File: rtl/aes_pkg.sv
// Shared AES types, the inverse S-box table and byte-extraction helper.
// Byte 0 of a state is the most significant byte ([127:120]).
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } inv_sb_state_e;

    localparam aes_byte_t INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_byte_t get_byte(aes_state_t s, int i);
        return s[127 - 8*i -: 8];
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// Combinational inverse S-box: one byte in, one byte out.
module inv_s_box
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Iterative inverse SubBytes: BYTES_PER_CYCLE inverse S-box lookups per clock,
// valid/ready on both sides, result held in the state register until accepted.
module aes_inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int unsigned NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    inv_sb_state_e    state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    aes_state_t       data_q, data_d;
    aes_state_t       sub_data;
    aes_byte_t        lane_out [BYTES_PER_CYCLE];

    // Lane i handles byte k*B+i of the current step.
    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
        aes_byte_t lane_in;
        assign lane_in = get_byte(data_q, int'(step_q) * int'(BYTES_PER_CYCLE) + i);
        inv_s_box u_inv_s_box (
            .in_byte  (lane_in),
            .out_byte (lane_out[i])
        );
    end

    always_comb begin
        sub_data = data_q;
        for (int i = 0; i < int'(BYTES_PER_CYCLE); i++) begin
            sub_data[127 - 8*(int'(step_q) * int'(BYTES_PER_CYCLE) + i) -: 8] = lane_out[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    step_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                data_d = sub_data;
                if (step_q == CNT_W'(NUM_STEPS - 1)) begin
                    step_d  = '0;
                    state_d = StDone;
                end else begin
                    step_d = step_q + CNT_W'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            data_q  <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Bench for aes_inv_sub_bytes: directed vectors and corner cases on the default
// build, then a random round-trip sweep on 1-, 4- and 16-lane builds in parallel.
module tb_aes_inv_sub_bytes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vin  [3];
    logic         rdy  [3];
    logic [127:0] din  [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] dout [3];

    aes_inv_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0])
    );
    aes_inv_sub_bytes #(.BYTES_PER_CYCLE(4)) u_dut_b4 (
        .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1])
    );
    aes_inv_sub_bytes #(.BYTES_PER_CYCLE(16)) u_dut_b16 (
        .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(rdy[2]), .in_data(din[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout[2])
    );

    // Forward S-box; the inverse reference is derived from it at start-up.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
        8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
        8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
        8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
        8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
        8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
        8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
        8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
        8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
        8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
        8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
        8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0]   inv_ref [256];
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [127:0] q2 [$];
    int           n_vec = 0;
    int           n_bad = 0;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;
    vec_t vecs [4];

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    function automatic logic [127:0] map_state(logic [127:0] s, bit inverse);
        logic [127:0] r;
        logic [7:0]   b;
        for (int i = 0; i < 16; i++) begin
            b = s[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = inverse ? inv_ref[b] : SBOX[b];
        end
        return r;
    endfunction

    task automatic sb_push(int idx, logic [127:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(int idx, output logic [127:0] v, output bit ok);
        v  = '0;
        ok = 1'b0;
        case (idx)
            0:       if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Called just after a posedge/negedge with the 4-lane DUT idle.
    task automatic accept_on_b4(string name, logic [127:0] x);
        int t = 0;
        @(negedge clk);
        while (!rdy[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[1]) fail({name, "_ready_timeout"});
        vin[1] = 1'b1;
        din[1] = x;
        @(posedge clk);
        #1 vin[1] = 1'b0;
    endtask

    task automatic wait_out_b4(string name, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ov[1]) got = 1'b1;
            else lat++;
        end
        if (!got) fail({name, "_out_timeout"});
    endtask

    task automatic apply_vec(string name, logic [127:0] x, logic [127:0] e);
        int           lat;
        bit           got;
        bit           ok;
        logic [127:0] p;
        accept_on_b4(name, x);
        sb_push(1, e);
        wait_out_b4(name, lat, got);
        if (got) begin
            check({name, "_latency"}, lat, 4);
            sb_pop(1, p, ok);
            if (ok) check({name, "_data"}, dout[1], p);
            else fail({name, "_sb_empty"});
            ordy[1] = 1'b1;
            @(posedge clk);
            #1 ordy[1] = 1'b0;
            @(negedge clk);
            check({name, "_valid_drop"}, ov[1], 0);
        end
    endtask

    task automatic run_sweep(int idx, int n);
        int           sent = 0;
        int           got  = 0;
        int           cyc  = 0;
        int           gap;
        bit           acc  = 1'b0;
        bit           ok;
        logic [127:0] orig = '0;
        logic [127:0] p;
        gap = int'($urandom_range(0, 3));
        while (got < n && cyc < n * 40) begin
            @(negedge clk);
            cyc++;
            if (vin[idx] && rdy[idx]) begin
                sb_push(idx, orig);
                sent++;
                acc = 1'b1;
            end
            if (ov[idx] && ordy[idx]) begin
                sb_pop(idx, p, ok);
                if (ok) check($sformatf("sweep_i%0d_n%0d", idx, got), dout[idx], p);
                else fail($sformatf("sweep_i%0d_sb_empty", idx));
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                vin[idx] = 1'b0;
                acc = 1'b0;
                gap = int'($urandom_range(0, 3));
            end
            if (!vin[idx] && sent < n) begin
                if (gap == 0) begin
                    orig     = {$urandom, $urandom, $urandom, $urandom};
                    din[idx] = map_state(orig, 1'b0);
                    vin[idx] = 1'b1;
                end else begin
                    gap--;
                end
            end
            ordy[idx] = ($urandom_range(0, 3) != 0);
        end
        if (got < n) fail($sformatf("sweep_i%0d_timeout", idx));
        vin[idx]  = 1'b0;
        ordy[idx] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        bit           got;
        bit           ok;
        int           seen;
        logic [127:0] p;
        logic [127:0] x2;

        for (int i = 0; i < 256; i++) inv_ref[SBOX[i]] = 8'(i);

        // Reset held with in_valid high: nothing may be captured.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vin[i]  = 1'b1;
            din[i]  = 128'h0123456789abcdef_fedcba9876543210;
            ordy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) vin[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_in_ready_i%0d", i), rdy[i], 1);
            check($sformatf("reset_out_valid_i%0d", i), ov[i], 0);
            check($sformatf("reset_out_data_i%0d", i), dout[i], '0);
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("reset_idle_valid_i%0d", i), ov[i], 0);

        vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{{16{8'h00}}, {16{8'h52}}};
        vecs[2] = '{{16{8'h16}}, {16{8'hff}}};
        vecs[3] = '{{16{8'hed}}, {16{8'h53}}};
        for (int i = 0; i < 4; i++) apply_vec($sformatf("vec%0d", i), vecs[i].din, vecs[i].dexp);

        // Backpressure: result held for 10 cycles while a new input waits.
        x2 = 128'h52096ad53036a538bf40a39e81f3d7fb;
        accept_on_b4("bp", {16{8'h63}});
        sb_push(1, {16{8'h00}});
        wait_out_b4("bp", lat, got);
        sb_pop(1, p, ok);
        if (!ok) fail("bp_sb_empty");
        vin[1] = 1'b1;
        din[1] = x2;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_valid_c%0d", c), ov[1], 1);
            check($sformatf("bp_data_c%0d", c), dout[1], p);
            check($sformatf("bp_in_ready_c%0d", c), rdy[1], 0);
            @(negedge clk);
        end
        ordy[1] = 1'b1;
        @(posedge clk);
        #1 ordy[1] = 1'b0;
        @(negedge clk);
        check("bp_next_in_ready", rdy[1], 1);
        @(posedge clk);
        sb_push(1, map_state(x2, 1'b1));
        #1 vin[1] = 1'b0;
        @(negedge clk);
        check("bp_next_accepted", rdy[1], 0);
        wait_out_b4("bp2", lat, got);
        if (got) begin
            sb_pop(1, p, ok);
            if (ok) check("bp2_data", dout[1], p);
            else fail("bp2_sb_empty");
            ordy[1] = 1'b1;
            @(posedge clk);
            #1 ordy[1] = 1'b0;
        end

        // Reset two cycles after accept: work in flight is dropped.
        accept_on_b4("rst_mid", 128'h00112233445566778899aabbccddeeff);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", rdy[1], 1);
        check("rst_mid_out_data", dout[1], '0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov[1]) seen++;
        end
        check("rst_mid_no_valid", seen, 0);
        apply_vec("rst_mid_fresh", 128'h637c777bf26b6fc53001672bfed7ab76,
                  128'h000102030405060708090a0b0c0d0e0f);

        fork
            run_sweep(0, 1000);
            run_sweep(1, 1000);
            run_sweep(2, 1000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
